dec_scan: RTL
=============

# dec_scan

Parametrised, registered one-hot decoder. It extends the plain 3-to-8 enable decoder with selectable direct, auto-scan and timed-pulse modes. It drives one-hot select lines (display digit strobes, bank or chip selects, test-pattern walkers) from a single clock domain. All outputs are registered.

## Interface
- SEL_W, 3, select width; output width is N = 2**SEL_W
- DWELL_W, 4, dwell counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; low forces outputs idle
- mode  in  2  00 DIRECT, 01 SCAN, 10 PULSE, 11 reserved
- sel  in  SEL_W  select index (DIRECT decode value, SCAN start index, PULSE target)
- dwell  in  DWELL_W  hold length; each SCAN step and each pulse lasts dwell+1 cycles
- load  in  1  PULSE trigger, single-cycle strobe
- y  out  N  one-hot (or all-zero) decoded output
- idx  out  SEL_W  index currently driven or last driven
- busy  out  1  high while a pulse is active
- wrap  out  1  one-cycle strobe when SCAN wraps from N-1 to 0

## Operation
- States: IDLE, DIRECT, SCAN, PWAIT, PACTIVE.
- Reset, asserted asynchronously:
  - state=IDLE
  - y=0, idx=0, busy=0, wrap=0
  - dwell counter cnt=0
- Transitions are evaluated every cycle:
  - en=0 from any state → IDLE. Next cycle y=0, busy=0, wrap=0, cnt=0; idx holds.
  - en=1, mode=00 → DIRECT. mode=01 → SCAN. mode=10 → PWAIT, or stays in PACTIVE while a pulse is running. mode=11 → IDLE.
  - A mode change mid-pulse aborts the pulse and y clears or updates on the next edge.
- DIRECT: y <= 1<<sel, idx <= sel, every cycle.
- SCAN:
  - On entry (previous state not SCAN): idx <= sel, cnt <= 0.
  - While in SCAN: y = 1<<idx. cnt counts 0..dwell.
  - When cnt==dwell: cnt <= 0 and idx <= idx+1 modulo N.
  - wrap <= 1 for exactly the cycle in which idx changes from N-1 to 0; otherwise wrap=0.
  - dwell is compared live, so a change takes effect on the current step. If cnt > dwell after a dwell decrease, the step ends on the next edge.
- PWAIT: y=0, busy=0. load=1 → PACTIVE, idx <= sel, cnt <= 0.
- PACTIVE:
  - y = 1<<idx, busy=1.
  - When cnt==dwell: y <= 0, busy <= 0, state → PWAIT.
  - load while busy is ignored, including on the final active cycle.
- dwell=0: each SCAN step lasts 1 cycle, and a pulse is 1 cycle wide.
- N=2**SEL_W, so idx never exceeds N-1; no out-of-range decode exists.

## Timing
- All outputs change only on a rising clk edge or on rst_n falling.
- DIRECT latency: y reflects sel one cycle after sampling.
- SCAN:
  - First y appears the cycle after entry with index sel.
  - Each index is held dwell+1 cycles; a full sweep is N*(dwell+1) cycles.
- PULSE:
  - y rises the cycle after load is sampled and is high for exactly dwell+1 cycles.
  - busy is coincident with y.
  - A new load is accepted in the first cycle after busy falls.
- en falling: y=0 on the next edge, regardless of mode.
- rst_n low mid-scan or mid-pulse: outputs clear immediately; operation restarts from IDLE once rst_n is released.
- y is always one-hot or zero, never multi-hot.

## Test plan
- Reset, then en=0, mode=00, sel=5 → y=8'h00, idx=0, busy=0, wrap=0.
- DIRECT sweep with en=1, sel=0..7 one per cycle → y=8'h01..8'h80, each one cycle after its sel. Then en=0 with sel=5 → y=8'h00 next cycle.
- SCAN with sel=6, dwell=2:
  - y=8'h40 for 3 cycles, then 8'h80 for 3 cycles, then 8'h01.
  - wrap=1 only on the cycle y becomes 8'h01.
  - With dwell=0, y walks one bit per cycle.
- PULSE with sel=3, dwell=4, load for one cycle:
  - y=8'h08 and busy=1 for exactly 5 cycles, then 0.
  - A second load during busy → no effect.
  - load on the first idle cycle → new 5-cycle pulse.
- Asynchronous reset mid-SCAN with idx=4 → y=0 and idx=0 without a clock edge. After release, SCAN restarts at sel.
- mode=11 with en=1 → y=0 and busy=0. Switching mode 01→10 mid-step → y=0 next cycle, then PWAIT waits for load.

Source files
------------

// File: rtl/dec_scan.sv
// ---------------------------------------------------------------------------
// dec_scan
//
// Registered one-hot decoder with three operating modes:
//   DIRECT : y follows 1<<sel one cycle after sampling.
//   SCAN   : walks a single hot bit upward from sel, holding each index for
//            dwell+1 cycles and wrapping from N-1 back to 0.
//   PULSE  : after a load strobe, drives 1<<sel for exactly dwell+1 cycles.
//
// Parameters:
//   SEL_W    select width; output width N = 2**SEL_W
//   DWELL_W  dwell counter width
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     block enable; low forces outputs idle
//   mode   00 DIRECT, 01 SCAN, 10 PULSE, 11 idle
//   sel    decode value / scan start index / pulse target
//   dwell  hold length; each scan step and each pulse lasts dwell+1 cycles
//   load   pulse trigger strobe
//   y      one-hot (or all-zero) registered output
//   idx    index currently or last driven
//   busy   high while a pulse is active
//   wrap   one-cycle strobe when the scan wraps from N-1 to 0
// ---------------------------------------------------------------------------
module dec_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  load,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  wrap
);

    localparam int N = 2**SEL_W;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DIRECT  = 3'd1;
    localparam logic [2:0] ST_SCAN    = 3'd2;
    localparam logic [2:0] ST_PWAIT   = 3'd3;
    localparam logic [2:0] ST_PACTIVE = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nx;
    logic [SEL_W-1:0]   idx_nx;
    logic [N-1:0]       y_nx;
    logic               busy_nx;
    logic               wrap_nx;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so y/idx/busy/wrap never glitch combinationally.
    // Dwell is compared with >= so that lowering dwell below the running
    // count ends the current step or pulse on the next edge.
    always_comb begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        idx_nx   = idx;
        y_nx     = '0;
        busy_nx  = 1'b0;
        wrap_nx  = 1'b0;
        if (en) begin
            case (mode)
                2'b00: begin
                    state_nx = ST_DIRECT;
                    idx_nx   = sel;
                    y_nx     = decode(sel);
                end
                2'b01: begin
                    state_nx = ST_SCAN;
                    if (state != ST_SCAN) begin
                        idx_nx = sel;
                    end else if (cnt >= dwell) begin
                        idx_nx  = idx + 1'b1;
                        wrap_nx = &idx;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                    y_nx = decode(idx_nx);
                end
                2'b10: begin
                    if (state == ST_PACTIVE) begin
                        if (cnt >= dwell) begin
                            state_nx = ST_PWAIT;
                        end else begin
                            state_nx = ST_PACTIVE;
                            cnt_nx   = cnt + 1'b1;
                            busy_nx  = 1'b1;
                            y_nx     = decode(idx);
                        end
                    end else if (state == ST_PWAIT && load) begin
                        state_nx = ST_PACTIVE;
                        idx_nx   = sel;
                        busy_nx  = 1'b1;
                        y_nx     = decode(sel);
                    end else begin
                        state_nx = ST_PWAIT;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            y     <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            y     <= y_nx;
            busy  <= busy_nx;
            wrap  <= wrap_nx;
        end
    end

endmodule
